ghostbus_host: RTL and testbench

Host-side initiator for the ghostbus: turns a valid/ready command stream (from a UART/Ethernet local-bus bridge) into single-cycle ghostbus write strobes and read strobes, then returns read data on a valid/ready response stream. Sits at the top of the design, driving the bus that auto-decoded peripherals (host-accessible registers and RAMs) respond to. Reads support bursts at incrementing addresses; writes are single-beat.

---
 rtl/ghostbus_host_pkg.sv | 21 ++
 rtl/ghostbus_host.sv | 147 ++++++++++++++
 tb/tb_ghostbus_host.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ghostbus_host_pkg.sv
// Shared types and constants for the ghostbus host initiator.
// Holds the FSM state encoding and the legal read-latency window.
package ghostbus_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RSP      = 3'd4
    } state_t;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;
    localparam int unsigned LAT_CNT_W  = 2;

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/ghostbus_host.sv
// Host-side ghostbus initiator: command stream in, single-cycle bus strobes out,
// read beats (optionally an incrementing burst) returned on a response stream.
module ghostbus_host
    import ghostbus_host_pkg::*;
#(
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned LW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [LW-1:0] cmd_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_din,
    output logic          busy
);

    if (!rd_lat_legal(RD_LAT)) begin : g_rd_lat_check
        $error("ghostbus_host: RD_LAT must be within %0d..%0d", RD_LAT_MIN, RD_LAT_MAX);
    end

    // Counter value in the strobe cycle; gb_din is captured when it reaches zero.
    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LAT - 1);

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [LW-1:0]          rem_q, rem_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   rsp_valid_d, rsp_last_d, gb_we_d, gb_re_d, busy_d;
    logic [DW-1:0]          rsp_data_d, gb_dout_d;
    logic [AW-1:0]          gb_addr_d;

    // Ready only when the FSM is idle and reset is not being applied.
    assign cmd_ready = ~busy & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            gb_addr   <= '0;
            gb_dout   <= '0;
            gb_we     <= 1'b0;
            gb_re     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_last  <= rsp_last_d;
            gb_addr   <= gb_addr_d;
            gb_dout   <= gb_dout_d;
            gb_we     <= gb_we_d;
            gb_re     <= gb_re_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_last_d  = rsp_last;
        gb_addr_d   = gb_addr;
        gb_dout_d   = gb_dout;
        gb_we_d     = 1'b0;
        gb_re_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d    = cmd_addr;
                    rem_d     = cmd_len;
                    gb_addr_d = cmd_addr;
                    if (cmd_write) begin
                        gb_we_d   = 1'b1;
                        gb_dout_d = cmd_wdata;
                        state_d   = ST_WR;
                    end else begin
                        gb_re_d = 1'b1;
                        cnt_d   = LAT_INIT;
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            // With RD_LAT=1 the data is captured at the end of the strobe cycle itself.
            ST_RD_ISSUE, ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = gb_din;
                    rsp_last_d  = (rem_q == '0);
                    state_d     = ST_RSP;
                end else begin
                    cnt_d   = cnt_q - LAT_CNT_W'(1);
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d    = addr_q + AW'(1);
                        rem_d     = rem_q - LW'(1);
                        gb_addr_d = addr_q + AW'(1);
                        gb_re_d   = 1'b1;
                        cnt_d     = LAT_INIT;
                        state_d   = ST_RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_ghostbus_host.sv
// Directed bench for ghostbus_host: vector table for single transfers, then
// hand-written burst, backpressure, mid-burst reset and read-latency sweep.
module tb_ghostbus_host;

    localparam int unsigned AW  = 24;
    localparam int unsigned DW  = 32;
    localparam int unsigned LW  = 8;
    localparam int unsigned LAT = 2;
    localparam logic [23:0] SW_ADDR = 24'hABCDEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [LW-1:0] cmd_len;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout, gb_din;
    logic          gb_we, gb_re, busy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int overlap = 0;

    typedef struct {
        int          cyc;
        logic [23:0] addr;
        logic [31:0] data;
        logic        last;
    } ev_t;

    ev_t we_q[$];
    ev_t re_q[$];
    ev_t rsp_q[$];
    int  rv_q[$];
    logic rv_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ghostbus_host #(.AW(AW), .DW(DW), .RD_LAT(LAT), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_we(gb_we), .gb_re(gb_re),
        .gb_din(gb_din), .busy(busy)
    );

    function automatic logic [31:0] mem_val(input logic [23:0] a);
        return (a == 24'h000004) ? 32'h0000_0042 : {8'hC3, a};
    endfunction

    // Peripheral model: data valid only in the cycle RD_LAT-1 after the strobe.
    always @(posedge clk) gb_din <= gb_re ? mem_val(gb_addr) : 32'hBAD0_BAD0;

    always @(negedge clk) begin
        if (gb_we) we_q.push_back('{cyc, gb_addr, gb_dout, 1'b0});
        if (gb_re) re_q.push_back('{cyc, gb_addr, 32'h0, 1'b0});
        if (gb_we && gb_re) overlap++;
        if (rsp_valid && rsp_ready) rsp_q.push_back('{cyc, 24'h0, rsp_data, rsp_last});
        if (rsp_valid && !rv_prev) rv_q.push_back(cyc);
        rv_prev <= rsp_valid;
    end

    // Latency sweep instances, one per legal RD_LAT.
    logic        sw_valid;
    logic        sw_ready[4];
    logic        sw_rv[4];
    logic        sw_rl[4];
    logic [31:0] sw_rd[4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int unsigned L = g + 1;
        logic [23:0] a;
        logic [31:0] dout, din;
        logic        we, re, bsy, vnow;
        logic [3:0]  sh = 4'h0;

        ghostbus_host #(.AW(24), .DW(32), .RD_LAT(L), .LW(8)) u_sw (
            .clk(clk), .rst(rst),
            .cmd_valid(sw_valid), .cmd_ready(sw_ready[g]), .cmd_write(1'b0),
            .cmd_addr(SW_ADDR), .cmd_wdata(32'h0), .cmd_len(8'h00),
            .rsp_valid(sw_rv[g]), .rsp_ready(1'b1), .rsp_data(sw_rd[g]), .rsp_last(sw_rl[g]),
            .gb_addr(a), .gb_dout(dout), .gb_we(we), .gb_re(re),
            .gb_din(din), .busy(bsy)
        );

        always @(posedge clk) sh <= {sh[2:0], re};
        assign vnow = (L == 1) ? re : sh[(L >= 2) ? L - 2 : 0];
        assign din  = vnow ? {8'h77, a} : 32'hBAD0_BAD0;
        always @(negedge clk) if (we || (we && bsy && dout != 32'h0)) overlap++;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        we_q.delete(); re_q.delete(); rsp_q.delete(); rv_q.delete();
    endtask

    task automatic do_cmd(input bit w, input logic [23:0] a, input logic [31:0] d,
                          input logic [7:0] l, output int acc);
        int k = 0;
        while (!cmd_ready && k < 50) begin
            tick();
            k++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_len = l;
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int bound, input string name);
        int k = 0;
        while (rsp_q.size() < n && k < bound) begin
            tick();
            k++;
        end
        if (rsp_q.size() < n) chk(name, 64'(rsp_q.size()), 64'(n));
    endtask

    typedef struct {
        bit          write;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc;
        logic [23:0] exp_a[4];
        logic [31:0] held;
        bit          stall_bad;
        int          n_re;
        int          first[4];
        logic [31:0] sdat[4];
        logic        slast[4];

        vecs[0] = '{1'b1, 24'h000010, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 24'h000004, 32'h0,         32'h0000_0042};
        vecs[2] = '{1'b1, 24'hFFFFFF, 32'h0000_0001, 32'h0};
        vecs[3] = '{1'b0, 24'h123456, 32'h0,         32'hC312_3456};
        vecs[4] = '{1'b1, 24'h000000, 32'hFFFF_FFFF, 32'h0};
        vecs[5] = '{1'b0, 24'hFFFFFF, 32'h0,         32'hC3FF_FFFF};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_len = '0; rsp_ready = 1'b0; sw_valid = 1'b0;

        tick(); tick(); tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_flags", 64'({rsp_valid, rsp_last, gb_we, gb_re, busy}), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_gb_addr", 64'(gb_addr), 64'd0);
        chk("rst_gb_dout", 64'(gb_dout), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(cmd_ready), 64'd1);

        // Single-beat transfers from the vector table.
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clear_q();
            do_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, 8'h00, acc);
            if (vecs[i].write) begin
                chk("wr_ready_n1", 64'(cmd_ready), 64'd0);
                tick();
                chk("wr_ready_n2", 64'(cmd_ready), 64'd1);
                tick(); tick();
                chk("wr_we_count", 64'(we_q.size()), 64'd1);
                if (we_q.size() > 0) begin
                    chk("wr_we_cycle", 64'(we_q[0].cyc - acc), 64'd0);
                    chk("wr_addr", 64'(we_q[0].addr), 64'(vecs[i].addr));
                    chk("wr_data", 64'(we_q[0].data), 64'(vecs[i].wdata));
                end
                chk("wr_no_rsp", 64'(rv_q.size() + re_q.size()), 64'd0);
            end else begin
                wait_rsp(1, 20, "rd_timeout");
                tick();
                chk("rd_re_count", 64'(re_q.size()), 64'd1);
                if (re_q.size() > 0) begin
                    chk("rd_re_cycle", 64'(re_q[0].cyc - acc), 64'd0);
                    chk("rd_addr", 64'(re_q[0].addr), 64'(vecs[i].addr));
                end
                if (rv_q.size() > 0) chk("rd_valid_cycle", 64'(rv_q[0] - acc), 64'(LAT));
                if (rsp_q.size() > 0) begin
                    chk("rd_data", 64'(rsp_q[0].data), 64'(vecs[i].exp_data));
                    chk("rd_last", 64'(rsp_q[0].last), 64'd1);
                end
            end
        end

        // Burst wrapping through the top of the address space.
        clear_q();
        exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF; exp_a[2] = 24'h000000; exp_a[3] = 24'h000001;
        do_cmd(1'b0, 24'hFFFFFE, 32'h0, 8'd3, acc);
        wait_rsp(4, 80, "burst_timeout");
        chk("burst_re_count", 64'(re_q.size()), 64'd4);
        for (int b = 0; b < 4; b++) begin
            if (re_q.size() > b && rsp_q.size() > b) begin
                chk("burst_addr", 64'(re_q[b].addr), 64'(exp_a[b]));
                chk("burst_data", 64'(rsp_q[b].data), 64'(mem_val(exp_a[b])));
                chk("burst_last", 64'(rsp_q[b].last), 64'(b == 3));
                chk("burst_beat_lat", 64'(rsp_q[b].cyc - re_q[b].cyc), 64'(LAT));
            end
        end

        // Backpressure on beat 2 for ten cycles.
        clear_q();
        do_cmd(1'b0, 24'h000100, 32'h0, 8'd3, acc);
        wait_rsp(1, 20, "bp_beat1_timeout");
        rsp_ready = 1'b0;
        for (int k = 0; k < 20 && !rsp_valid; k++) tick();
        chk("bp_valid", 64'(rsp_valid), 64'd1);
        held = rsp_data;
        n_re = re_q.size();
        stall_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!rsp_valid || rsp_data !== held || rsp_last !== 1'b0) stall_bad = 1'b1;
        end
        chk("bp_stable", 64'(stall_bad), 64'd0);
        chk("bp_held_data", 64'(held), 64'(mem_val(24'h000101)));
        chk("bp_no_re", 64'(re_q.size()), 64'(n_re));
        rsp_ready = 1'b1;
        wait_rsp(4, 80, "bp_timeout");
        for (int b = 0; b < 4; b++) begin
            if (rsp_q.size() > b) begin
                chk("bp_data", 64'(rsp_q[b].data), 64'(mem_val(24'h000100 + 24'(b))));
                chk("bp_last", 64'(rsp_q[b].last), 64'(b == 3));
            end
        end

        // Reset during the wait state of beat 2.
        clear_q();
        do_cmd(1'b0, 24'h000200, 32'h0, 8'd3, acc);
        for (int k = 0; k < 40 && re_q.size() < 2; k++) tick();
        chk("rst_mid_reached", 64'(re_q.size()), 64'd2);
        rst = 1'b1;
        tick();
        chk("rst_mid_flags", 64'({rsp_valid, rsp_last, gb_we, gb_re, busy, cmd_ready}), 64'd0);
        chk("rst_mid_data", 64'(rsp_data), 64'd0);
        chk("rst_mid_addr", 64'(gb_addr), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("rst_mid_no_partial", 64'(rv_q.size()), 64'd1);
        clear_q();
        do_cmd(1'b0, 24'h000004, 32'h0, 8'd0, acc);
        wait_rsp(1, 20, "post_rst_timeout");
        if (rsp_q.size() > 0) begin
            chk("post_rst_data", 64'(rsp_q[0].data), 64'h42);
            chk("post_rst_last", 64'(rsp_q[0].last), 64'd1);
        end
        if (rv_q.size() > 0) chk("post_rst_cycle", 64'(rv_q[0] - acc), 64'(LAT));

        // Read-latency sweep: first rsp_valid in cycle N+1+RD_LAT.
        for (int g = 0; g < 4; g++) first[g] = -1;
        chk("sw_ready", 64'({sw_ready[0], sw_ready[1], sw_ready[2], sw_ready[3]}), 64'hF);
        sw_valid = 1'b1;
        tick();
        acc = cyc;
        sw_valid = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            for (int g = 0; g < 4; g++) begin
                if (sw_rv[g] && first[g] < 0) begin
                    first[g] = cyc - acc;
                    sdat[g]  = sw_rd[g];
                    slast[g] = sw_rl[g];
                end
            end
            tick();
        end
        for (int g = 0; g < 4; g++) begin
            chk("sweep_valid_cycle", 64'(first[g]), 64'(g + 1));
            chk("sweep_data", 64'(sdat[g]), 64'({8'h77, SW_ADDR}));
            chk("sweep_last", 64'(slast[g]), 64'd1);
        end

        chk("we_re_overlap", 64'(overlap), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
